// File: rtl/network_pkg.sv
// Shared definitions for the network layer blocks: default MAC geometry,
// pipeline latency helper, sideband tag type and the round/saturate helper.
package network_pkg;

  localparam int NET_A_W        = 16;
  localparam int NET_B_W        = 14;
  localparam int NET_B_SIGNED   = 0;
  localparam int NET_MUL_STAGES = 2;
  localparam int NET_ACC_W      = 40;
  localparam int NET_FRAC_SH    = 13;
  localparam int NET_OUT_W      = 16;

  // Sample framing that rides alongside the datapath.
  typedef struct packed {
    logic first;
    logic last;
  } mac_tag_t;

  // Rounded result plus saturation flag; val is wide enough for any ACC_W <= 63.
  typedef struct packed {
    logic signed [63:0] val;
    logic               ovf;
  } sat_res_t;

  // Last accepted sample to out_valid, in ce-cycles.
  function automatic int mac_lat(input int mul_stages);
    return mul_stages + 3;
  endfunction

  // Round-half-up arithmetic shift, optionally clamped to a signed out_w range.
  // Done in 64 bits so the rounding constant can never overflow the sum.
  function automatic sat_res_t round_sat(input logic signed [63:0] acc,
                                         input int frac_sh, input int out_w,
                                         input logic sat_en);
    sat_res_t res;
    logic signed [63:0] r, hi, lo;
    r = acc;
    if (frac_sh > 0) r = (acc + (64'sd1 <<< (frac_sh - 1))) >>> frac_sh;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    res.val = r;
    res.ovf = 1'b0;
    if (sat_en && (r > hi)) begin
      res.val = hi;
      res.ovf = 1'b1;
    end else if (sat_en && (r < lo)) begin
      res.val = lo;
      res.ovf = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/network_mac_mul_pipe.sv
// Input register stage followed by MUL_STAGES product registers. Extra stages
// are plain delay registers so synthesis can retime them into the DSP.
// Valid and first/last travel as shift registers next to the product.
module network_mac_mul_pipe import network_pkg::*; #(
  parameter int A_W        = NET_A_W,
  parameter int B_W        = NET_B_W,
  parameter int B_SIGNED   = NET_B_SIGNED,
  parameter int MUL_STAGES = NET_MUL_STAGES
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ce,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic signed [A_W-1:0]    a,
  input  logic        [B_W-1:0]    b,
  output logic signed [A_W+B_W:0]  prod,
  output logic                     prod_vld,
  output mac_tag_t                 prod_tag
);

  localparam int P_W = A_W + B_W + 1;

  logic signed [B_W:0]   b_ext;
  mac_tag_t              tag_in;
  logic signed [A_W-1:0] a_q;
  logic signed [B_W:0]   b_q;
  logic [MUL_STAGES:0]   vld_pipe;
  mac_tag_t [MUL_STAGES:0] tag_pipe;
  logic signed [P_W-1:0] prod_pipe [1:MUL_STAGES];

  // Widen b by one bit so a single signed multiplier covers both weight modes.
  assign b_ext = (B_SIGNED != 0) ? {b[B_W-1], b} : {1'b0, b};

  // Framing bits only mean something on a real sample.
  assign tag_in = '{first: in_valid & in_first, last: in_valid & in_last};

  // Input regs, multiply, then delay stages; everything frozen when ce=0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      vld_pipe <= '0;
      tag_pipe <= '0;
      for (int i = 1; i <= MUL_STAGES; i++) prod_pipe[i] <= '0;
    end else if (ce) begin
      a_q          <= a;
      b_q          <= b_ext;
      vld_pipe     <= {vld_pipe[MUL_STAGES-1:0], in_valid};
      tag_pipe     <= {tag_pipe[MUL_STAGES-1:0], tag_in};
      prod_pipe[1] <= a_q * b_q;
      for (int i = 2; i <= MUL_STAGES; i++) prod_pipe[i] <= prod_pipe[i-1];
    end
  end

  assign prod     = prod_pipe[MUL_STAGES];
  assign prod_vld = vld_pipe[MUL_STAGES];
  assign prod_tag = tag_pipe[MUL_STAGES];

endmodule

// File: rtl/network_mac_pipe.sv
// Pipelined signed MAC: S0 -> product regs -> accumulator -> round/narrow out reg.
// Define NETWORK_MAC_SAT_EN to clamp out-of-range results and flag out_ovf;
// otherwise the result wraps to OUT_W bits and out_ovf stays 0.
module network_mac_pipe import network_pkg::*; #(
  parameter int A_W        = NET_A_W,
  parameter int B_W        = NET_B_W,
  parameter int B_SIGNED   = NET_B_SIGNED,
  parameter int MUL_STAGES = NET_MUL_STAGES,
  parameter int ACC_W      = NET_ACC_W,
  parameter int FRAC_SH    = NET_FRAC_SH,
  parameter int OUT_W      = NET_OUT_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ce,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic signed [A_W-1:0]   a,
  input  logic        [B_W-1:0]   b,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_ovf
);

`ifdef NETWORK_MAC_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic signed [A_W+B_W:0] prod;
  logic                    prod_vld;
  mac_tag_t                prod_tag;
  logic signed [ACC_W-1:0] acc_q, sum_d, sum_q;
  logic                    sum_vld;
  sat_res_t                rs;
  logic                    unused_rs_hi;

  network_mac_mul_pipe #(
    .A_W(A_W), .B_W(B_W), .B_SIGNED(B_SIGNED), .MUL_STAGES(MUL_STAGES)
  ) u_mul (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .a(a), .b(b),
    .prod(prod), .prod_vld(prod_vld), .prod_tag(prod_tag)
  );

  // A first sample restarts the sum; otherwise add onto the running total.
  always_comb begin
    sum_d = (prod_tag.first ? '0 : acc_q) + ACC_W'(prod);
  end

  // Running sum clears on last so an unframed follow-on sample starts from 0;
  // the completed sum is parked in sum_q for the output stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q   <= '0;
      sum_q   <= '0;
      sum_vld <= 1'b0;
    end else if (ce) begin
      sum_vld <= prod_vld & prod_tag.last;
      if (prod_vld) begin
        acc_q <= prod_tag.last ? '0 : sum_d;
        sum_q <= sum_d;
      end
    end
  end

  assign rs           = round_sat(64'(sum_q), FRAC_SH, OUT_W, SAT_EN);
  assign unused_rs_hi = ^rs.val[63:OUT_W];

  // One ce-cycle pulse per finished sum; data/ovf hold until the next one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (ce) begin
      out_valid <= sum_vld;
      if (sum_vld) begin
        out_data <= rs.val[OUT_W-1:0];
        out_ovf  <= rs.ovf;
      end
    end
  end

endmodule

// File: tb/tb_network_mac_pipe.sv
// Directed bench for network_mac_pipe at default parameters (b=8192 == 1.0).
module tb_network_mac_pipe;

  logic               clk = 1'b0;
  logic               reset_n, ce, in_valid, in_first, in_last;
  logic signed [15:0] a;
  logic        [13:0] b;
  logic               out_valid, out_ovf;
  logic signed [15:0] out_data;
  int checks = 0;
  int errors = 0;

  network_mac_pipe dut (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .a(a), .b(b),
    .out_valid(out_valid), .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  // Present one sample at the falling edge; it is captured by the next rising edge.
  task automatic send(input int av, input int bv, input logic f, input logic l);
    @(negedge clk);
    ce = 1'b1; in_valid = 1'b1; in_first = f; in_last = l;
    a = 16'(av); b = 14'(bv);
    @(posedge clk);
  endtask

  // Watch n cycles after the last capture edge (k=1 is just after that edge).
  // Pulses are counted only when the preceding edge had ce=1. ce is dropped for
  // stall_len cycles starting at k=stall_at.
  task automatic collect(input int n, input int stall_at, input int stall_len,
                         output int npulse, output int lat,
                         output logic signed [15:0] d, output logic o);
    logic prev_ce;
    npulse = 0; lat = -1; d = '0; o = 1'b0; prev_ce = ce;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (out_valid && prev_ce) begin
        npulse++;
        if (lat < 0) lat = k;
        d = out_data;
        o = out_ovf;
      end
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      ce = !(k >= stall_at && k < stall_at + stall_len);
      prev_ce = ce;
    end
    ce = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ce = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 16'sd0) begin errors++; $display("FAIL reset_data got %0d want 0", out_data); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", out_ovf); end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    int np, lat; logic signed [15:0] d; logic o;
    send(100, 8192, 1, 1);
    collect(12, 0, 0, np, lat, d, o);
    checks++; if (lat !== 5) begin errors++; $display("FAIL single_lat got %0d want 5", lat); end
    checks++; if (np !== 1) begin errors++; $display("FAIL single_pulses got %0d want 1", np); end
    checks++; if (d !== 16'sd100) begin errors++; $display("FAIL single_data got %0d want 100", d); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL single_ovf got %b want 0", o); end
  endtask

  task automatic test_back_to_back();
    int np, lat; logic signed [15:0] d; logic o;
    send(1000, 8192, 1, 0);
    send(1000, 8192, 0, 0);
    send(1000, 8192, 0, 1);
    collect(12, 0, 0, np, lat, d, o);
    checks++; if (np !== 1) begin errors++; $display("FAIL b2b_pulses got %0d want 1", np); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_lat got %0d want 5", lat); end
    checks++; if (d !== 16'sd3000) begin errors++; $display("FAIL b2b_data got %0d want 3000", d); end
  endtask

  // a*4096 = a*0.5; round-half-up: 0.5 -> 1, -0.5 -> 0, -1.5 -> -1.
  task automatic test_rounding();
    int av [3] = '{1, -1, -3};
    int ex [3] = '{1, 0, -1};
    int np, lat; logic signed [15:0] d, e; logic o;
    for (int i = 0; i < 3; i++) begin
      send(av[i], 4096, 1, 1);
      collect(10, 0, 0, np, lat, d, o);
      e = 16'(ex[i]);
      checks++; if (np !== 1) begin errors++; $display("FAIL round%0d_pulses got %0d want 1", i, np); end
      checks++; if (d !== e) begin errors++; $display("FAIL round%0d_data got %0d want %0d", i, d, e); end
    end
  endtask

  // A non-first sample right after a last must start from zero: 5, not 105.
  task automatic test_clear_after_last();
    int np, lat; logic signed [15:0] d; logic o;
    send(100, 8192, 1, 1);
    send(5, 8192, 0, 1);
    collect(12, 0, 0, np, lat, d, o);
    checks++; if (np !== 2) begin errors++; $display("FAIL clear_pulses got %0d want 2", np); end
    checks++; if (d !== 16'sd5) begin errors++; $display("FAIL clear_data got %0d want 5", d); end
  endtask

  // 4*32767*16383 = 2147287044; (+4096)>>13 = 262120 = 0x3FFE8.
  task automatic test_overflow();
    int np, lat; logic signed [15:0] d, e; logic o, eo;
`ifdef NETWORK_MAC_SAT_EN
    e = 16'sd32767; eo = 1'b1;
`else
    e = 16'shFFE8; eo = 1'b0;
`endif
    send(32767, 16383, 1, 0);
    send(32767, 16383, 0, 0);
    send(32767, 16383, 0, 0);
    send(32767, 16383, 0, 1);
    collect(12, 0, 0, np, lat, d, o);
    checks++; if (np !== 1) begin errors++; $display("FAIL ovf_pulses got %0d want 1", np); end
    checks++; if (d !== e) begin errors++; $display("FAIL ovf_data got %0d want %0d", d, e); end
    checks++; if (o !== eo) begin errors++; $display("FAIL ovf_flag got %b want %b", o, eo); end
  endtask

  task automatic test_ce_stall();
    int np, lat; logic signed [15:0] d; logic o;
    // Stall between samples 2 and 3 with a junk first&last sample on the inputs.
    send(1000, 8192, 1, 0);
    send(1000, 8192, 0, 0);
    @(negedge clk);
    ce = 1'b0; in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; a = 16'sd777;
    repeat (3) @(posedge clk);
    send(1000, 8192, 0, 1);
    collect(12, 0, 0, np, lat, d, o);
    checks++; if (np !== 1) begin errors++; $display("FAIL stall_in_pulses got %0d want 1", np); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL stall_in_lat got %0d want 5", lat); end
    checks++; if (d !== 16'sd3000) begin errors++; $display("FAIL stall_in_data got %0d want 3000", d); end
    // Stall 3 cycles while the sum is in flight: result 3 cycles later.
    send(1000, 8192, 1, 0);
    send(1000, 8192, 0, 0);
    send(1000, 8192, 0, 1);
    collect(14, 2, 3, np, lat, d, o);
    checks++; if (np !== 1) begin errors++; $display("FAIL stall_fl_pulses got %0d want 1", np); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL stall_fl_lat got %0d want 8", lat); end
    checks++; if (d !== 16'sd3000) begin errors++; $display("FAIL stall_fl_data got %0d want 3000", d); end
  endtask

  task automatic test_reset_midstream();
    int np, lat; logic signed [15:0] d; logic o;
    send(1000, 8192, 1, 0);
    send(1000, 8192, 0, 0);
    @(negedge clk);
    reset_n = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 16'sd0) begin errors++; $display("FAIL rstmid_data got %0d want 0", out_data); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL rstmid_ovf got %b want 0", out_ovf); end
    reset_n = 1'b1;
    send(7, 8192, 1, 1);
    collect(12, 0, 0, np, lat, d, o);
    checks++; if (np !== 1) begin errors++; $display("FAIL rstmid_pulses got %0d want 1", np); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL rstmid_lat got %0d want 5", lat); end
    checks++; if (d !== 16'sd7) begin errors++; $display("FAIL rstmid_out got %0d want 7", d); end
    // A complete sum still in flight when reset hits must never appear.
    send(50, 8192, 1, 1);
    @(negedge clk);
    reset_n = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    collect(10, 0, 0, np, lat, d, o);
    checks++; if (np !== 0) begin errors++; $display("FAIL rst_inflight_pulses got %0d want 0", np); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_rounding();
    test_clear_after_last();
    test_overflow();
    test_ce_stall();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
